// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the LEGv8 datapath: fetch, decode, execute, memory and
// write-back phases with ready handshakes, a wait timeout and a retired-instruction counter.
module multicycle_sequencer #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [10:0]      opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_to_loc,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ClsIllegal,
        ClsRtype,
        ClsLdur,
        ClsStur,
        ClsCbz,
        ClsB
    } cls_e;

    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] LastWait = WaitW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TimeoutEn = (TIMEOUT > 0);

    state_e           state_q, state_d;
    cls_e             cls_q, dec_cls;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q, bus_error_q;
    logic             retire, set_illegal, set_bus_error;
    logic             waiting, timeout_hit;

    always_comb begin
        dec_cls = ClsIllegal;
        if (opcode == 11'b11111000010) begin
            dec_cls = ClsLdur;
        end else if (opcode == 11'b11111000000) begin
            dec_cls = ClsStur;
        end else if (opcode inside {11'b10001011000, 11'b11001011000,
                                    11'b10001010000, 11'b10101010000}) begin
            dec_cls = ClsRtype;
        end else if (opcode[10:3] == 8'b10110100) begin
            dec_cls = ClsCbz;
        end else if (opcode[10:5] == 6'b000101) begin
            dec_cls = ClsB;
        end
    end

    assign waiting     = ((state_q == StFetch) && !imem_ready) ||
                         ((state_q == StMem) && !dmem_ready);
    // The cycle that would be the TIMEOUT-th wait gives up; a ready in that cycle still wins.
    assign timeout_hit = TimeoutEn && waiting && (wait_q == LastWait);

    always_comb begin
        state_d       = state_q;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        reg_to_loc    = 1'b0;
        alu_src       = 1'b0;
        alu_op        = 2'b00;
        dmem_read     = 1'b0;
        dmem_write    = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;
        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = StDecode;
                end else if (timeout_hit) begin
                    state_d       = StHalt;
                    set_bus_error = 1'b1;
                end
            end
            StDecode: begin
                case (dec_cls)
                    ClsIllegal: begin
                        state_d     = StHalt;
                        set_illegal = 1'b1;
                    end
                    ClsB: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                    end
                    default: state_d = StExec;
                endcase
            end
            StExec: begin
                case (cls_q)
                    ClsRtype: begin
                        alu_op  = 2'b10;
                        state_d = StWb;
                    end
                    ClsLdur: begin
                        alu_src = 1'b1;
                        state_d = StMem;
                    end
                    ClsStur: begin
                        reg_to_loc = 1'b1;
                        alu_src    = 1'b1;
                        state_d    = StMem;
                    end
                    ClsCbz: begin
                        reg_to_loc = 1'b1;
                        alu_op     = 2'b01;
                        pc_write   = 1'b1;
                        pc_src     = zero;
                        retire     = 1'b1;
                    end
                    default: state_d = StHalt;
                endcase
            end
            StMem: begin
                // Address and store-data selects stay put for the whole access.
                alu_src    = 1'b1;
                reg_to_loc = (cls_q == ClsStur);
                dmem_read  = (cls_q == ClsLdur);
                dmem_write = (cls_q == ClsStur);
                if (dmem_ready) begin
                    if (cls_q == ClsLdur) begin
                        state_d = StWb;
                    end else begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d       = StHalt;
                    set_bus_error = 1'b1;
                end
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                if (cls_q == ClsLdur) begin
                    mem_to_reg = 1'b1;
                    alu_src    = 1'b1;
                end else begin
                    alu_op = 2'b10;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StIdle;
        endcase
        if (retire) state_d = run ? StFetch : StIdle;
    end

    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting && TimeoutEn) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cls_q       <= ClsIllegal;
            wait_q      <= '0;
            retired_q   <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == StDecode) cls_q <= dec_cls;
            if (retire) retired_q <= retired_q + CNT_W'(1);
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_error) bus_error_q <= 1'b1;
        end
    end

    assign state     = state_q;
    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;
    assign retired   = retired_q;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Control FSM that sequences the LEGv8 datapath (PC, instruction memory, register bank, ALU, data memory) over multiple cycles per instruction.
- Replaces the single-cycle control decode.
- Handles ready/request handshakes with instruction and data memory, with a wait-timeout.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TIMEOUT, 16, max cycles waiting for imem_ready/dmem_ready before bus error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = keep fetching; sampled at IDLE and at the end of each instruction.
- opcode  in  11  instruction[31:21] from the instruction register.
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  latch the instruction register.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch target.
- reg_to_loc  out  1  register-bank read-port-2 select (1 = Rt for STUR/CBZ).
- alu_src  out  1  1 = sign-extended immediate.
- alu_op  out  2  00 = address add, 01 = pass B (CBZ), 10 = R-type.
- dmem_read  out  1  data memory read request.
- dmem_write  out  1  data memory write request.
- mem_to_reg  out  1  write-back from memory.
- reg_write  out  1  register bank write enable.
- state  out  3  current state, for debug.
- illegal  out  1  sticky: undecodable opcode.
- bus_error  out  1  sticky: handshake timeout.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state = IDLE(0); all outputs 0; retired = 0; timeout counter = 0. Reset mid-instruction aborts immediately; dmem_read/dmem_write deassert on that edge.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Output timing: outputs decode combinationally from state plus the instruction class registered in DECODE. pc_src additionally depends combinationally on zero in EXEC for CBZ.
- Instruction classes (decoded from opcode):
  - LDUR = 11111000010
  - STUR = 11111000000
  - R-type = ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - CBZ = opcode[10:3] 10110100
  - B = opcode[10:5] 000101
  - any other value = illegal
- IDLE: all controls 0. Go to FETCH when run = 1.
- FETCH: imem_req = 1. When imem_ready = 1: ir_write pulses that cycle, then go to DECODE.
- DECODE (1 cycle): class is registered.
  - Illegal: go to HALT and set illegal.
  - B: pc_write = 1, pc_src = 1, retire.
  - Anything else: go to EXEC.
- EXEC (1 cycle): alu_op and alu_src are set per class; reg_to_loc = 1 for STUR/CBZ.
  - R-type: go to WB.
  - LDUR/STUR: go to MEM.
  - CBZ: pc_write = 1, pc_src = zero, retire.
- MEM: dmem_read (LDUR) or dmem_write (STUR) held high until dmem_ready.
  - On ready, LDUR: go to WB.
  - On ready, STUR: pc_write = 1, pc_src = 0, retire.
  - Address controls (alu_op = 00, alu_src = 1) are held stable throughout MEM.
- WB (1 cycle): reg_write = 1, mem_to_reg = 1 for LDUR, pc_write = 1, pc_src = 0, retire. R-type controls are held.
- Retire: retired += 1 (wraps modulo 2^CNT_W). Next state is FETCH if run = 1, else IDLE. Each instruction produces exactly one pc_write pulse.
- Latency with zero-wait memories (ready in the same cycle as the request):
  - B: 2 cycles.
  - CBZ: 3 cycles.
  - R-type and STUR: 4 cycles.
  - LDUR: 5 cycles.
  - Each wait cycle adds 1.
- Timeout:
  - The counter increments each FETCH/MEM cycle without ready and clears on state change.
  - When the counter reaches TIMEOUT with ready still low, the next state is HALT and bus_error is set.
  - If ready and the final timeout cycle coincide, ready wins.
- HALT: all controls 0; illegal/bus_error held; run is ignored; exit only via reset.
- run deasserted mid-instruction: the current instruction completes, then the FSM goes to IDLE.

Test Plan:
- Reset, run = 1, both ready tied 1, opcode ADD: states 1,2,3,5 repeating; reg_write is high in WB only; retired = 3 after 12 cycles.
- LDUR with dmem_ready delayed 3 cycles: dmem_read high for 4 cycles; WB follows with mem_to_reg = 1 and reg_write = 1; total instruction time 8 cycles.
- CBZ with zero = 1 and then zero = 0: pc_write pulses in EXEC with pc_src = 1 and then pc_src = 0; reg_write is never asserted.
- Opcode 00000000000: HALT reached after DECODE; illegal = 1 and stays 1 under run toggling; cleared only by reset.
- TIMEOUT = 4, imem_ready held 0: bus_error = 1 and state = 6 after 4 FETCH cycles. Repeat with ready arriving on the 4th cycle: no error.
- Assert reset during MEM of STUR: the next cycle shows dmem_write = 0, state = 0, retired = 0.
